// File: rtl/gb_lcd_pkg.sv
// Shared Game Boy LCD definitions: screen geometry, shade type, counter
// widths and the transmitter state encoding. The GB-to-VGA converter imports
// the same package so both sides agree on geometry and shade polarity.
package gb_lcd_pkg;

    // Screen geometry
    localparam int unsigned GB_W      = 160;
    localparam int unsigned GB_H      = 144;
    localparam int unsigned GB_PIXELS = 23040;

    // Counter and bus widths
    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned CYC_W   = 12;
    localparam int unsigned LINE_W  = 8;
    localparam int unsigned X_W     = 8;
    localparam int unsigned SHADE_W = 2;

    // 2-bit shade: 0 white .. 3 black
    typedef logic [SHADE_W-1:0] shade_t;

    // Transmitter top-level state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

    // Panel data is driven inverted relative to the framebuffer shade
    function automatic shade_t shade_inv(input shade_t s);
        return ~s;
    endfunction

endpackage

// File: rtl/gb_lcd_tx.sv
// Free-running Game Boy LCD transmitter.
// Fetches 160x144 2-bit pixels from a framebuffer (one-cycle read latency)
// and replays them on the original LCD bus: lcd_hsync falling edge samples
// pixel 0 of a line, each lcd_clk falling edge samples pixels 1..159, and
// lcd_vsync is high for the whole of line 0.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   enable          - frames may start; sampled only in IDLE and at frame end
//   pix_rd/pix_addr - framebuffer fetch strobe and address (y*160+x)
//   pix_data        - fetched shade, valid the cycle after pix_rd
//   lcd_clk/lcd_hsync/lcd_vsync/lcd_data - LCD bus
//   frame_done      - one-cycle pulse on the last cycle of a frame
module gb_lcd_tx
    import gb_lcd_pkg::*;
#(
    parameter int unsigned CLK_HALF  = 8,
    parameter int unsigned HS_CYC    = 16,
    parameter int unsigned LINE_CYC  = 2800,
    parameter int unsigned VIS_LINES = 144,
    parameter int unsigned TOT_LINES = 154
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [1:0]        pix_data,
    output logic              lcd_clk,
    output logic              lcd_hsync,
    output logic              lcd_vsync,
    output logic [1:0]        lcd_data,
    output logic              frame_done
);

    // Phase counter spans one lcd_clk period
    localparam int unsigned PH_W = $clog2(2 * CLK_HALF);

    localparam logic [CYC_W-1:0]  C_LAST    = CYC_W'(LINE_CYC - 1);
    localparam logic [CYC_W-1:0]  C_HS      = CYC_W'(HS_CYC);
    localparam logic [CYC_W-1:0]  C_UPD0    = CYC_W'(2);
    localparam logic [LINE_W-1:0] L_LAST    = LINE_W'(TOT_LINES - 1);
    localparam logic [LINE_W-1:0] L_VIS     = LINE_W'(VIS_LINES);
    localparam logic [X_W-1:0]    X_FIRST   = X_W'(1);
    localparam logic [X_W-1:0]    X_END     = X_W'(GB_W);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * CLK_HALF - 1);
    localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(CLK_HALF);
    localparam logic [PH_W-1:0]   PH_UPD    = PH_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(GB_W);

    // Timing state
    tx_state_t         state_q, state_n;
    logic [CYC_W-1:0]  c_q, c_n;
    logic [LINE_W-1:0] line_q, line_n;
    logic [X_W-1:0]    x_q, x_n;
    logic [PH_W-1:0]   ph_q, ph_n;
    logic [ADDR_W-1:0] base_q, base_n;

    // Output values for the cycle being entered
    logic              run_n;
    logic              vis_n;
    logic              win_n;
    logic              rd_n;
    logic              upd_n;
    logic [ADDR_W-1:0] addr_n;
    logic              clk_n;
    logic              hs_n;
    logic              vs_n;
    logic              done_n;

    // Next-state: cycle/line counters, pixel index x and its lcd_clk phase.
    // x=0 is the hsync-sampled pixel; x=1..159 each own a 2*CLK_HALF window
    // starting at c=HS_CYC; x=160 means the line's pixels are exhausted.
    always_comb begin
        state_n = state_q;
        c_n     = c_q;
        line_n  = line_q;
        x_n     = x_q;
        ph_n    = ph_q;
        base_n  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_n = ST_RUN;
                    c_n     = '0;
                    line_n  = '0;
                    x_n     = '0;
                    ph_n    = '0;
                    base_n  = '0;
                end
            end
            ST_RUN: begin
                if (c_q == C_LAST) begin
                    c_n  = '0;
                    x_n  = '0;
                    ph_n = '0;
                    if (line_q == L_LAST) begin
                        line_n = '0;
                        base_n = '0;
                        if (!enable) begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        line_n = line_q + 1'b1;
                        base_n = base_q + ADDR_STEP;
                    end
                end else begin
                    c_n = c_q + 1'b1;
                    if (c_n == C_HS) begin
                        x_n  = X_FIRST;
                        ph_n = '0;
                    end else if (x_q != '0 && x_q != X_END) begin
                        if (ph_q == PH_LAST) begin
                            ph_n = '0;
                            x_n  = x_q + 1'b1;
                        end else begin
                            ph_n = ph_q + 1'b1;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output decode from the next state so registered outputs line up with c
    always_comb begin
        run_n  = (state_n == ST_RUN);
        vis_n  = run_n && (line_n < L_VIS);
        win_n  = (x_n != '0) && (x_n != X_END);
        rd_n   = vis_n && (((x_n == '0) && (c_n == '0)) || (win_n && (ph_n == '0)));
        upd_n  = vis_n && (((x_n == '0) && (c_n == C_UPD0)) || (win_n && (ph_n == PH_UPD)));
        addr_n = rd_n ? (base_n + ADDR_W'(x_n)) : '0;
        clk_n  = vis_n && win_n && (ph_n < PH_HALF);
        hs_n   = vis_n && (c_n < C_HS);
        vs_n   = run_n && (line_n == '0);
        done_n = run_n && (line_n == L_LAST) && (c_n == C_LAST);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            c_q        <= '0;
            line_q     <= '0;
            x_q        <= '0;
            ph_q       <= '0;
            base_q     <= '0;
            pix_rd     <= 1'b0;
            pix_addr   <= '0;
            lcd_clk    <= 1'b0;
            lcd_hsync  <= 1'b0;
            lcd_vsync  <= 1'b0;
            lcd_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            c_q        <= c_n;
            line_q     <= line_n;
            x_q        <= x_n;
            ph_q       <= ph_n;
            base_q     <= base_n;
            pix_rd     <= rd_n;
            pix_addr   <= addr_n;
            lcd_clk    <= clk_n;
            lcd_hsync  <= hs_n;
            lcd_vsync  <= vs_n;
            frame_done <= done_n;
            // Blank lines and IDLE force data low; otherwise hold between updates
            if (!vis_n) begin
                lcd_data <= '0;
            end else if (upd_n) begin
                lcd_data <= shade_inv(pix_data);
            end
        end
    end

endmodule
